// File: rtl/gmii_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : gmii_tx_sched
// Brief   : Arbitrates video lines and audio aux blocks onto a GMII transmitter.
// Revision: 1.0
// ============================================================================
module gmii_tx_sched #(
   parameter logic [3:0]  AUD_MAX   = 4'd8,
   parameter logic [3:0]  VIDAX_MAX = 4'd4,
   parameter logic [15:0] AUD_WAIT  = 16'd2000,
   parameter logic [7:0]  START_TO  = 8'd64,
   parameter logic [7:0]  GAP_CYC   = 8'd12
) (
   input  logic        tx_clk,
   input  logic        sys_rst,
   input  logic        vid_ready,
   input  logic [4:0]  aud_level,
   input  logic        tx_en,
   output logic        sched_go,
   output logic [1:0]  pkt_type,
   output logic [3:0]  ade_num,
   output logic        busy,
   output logic        err_start,
   output logic [15:0] pkt_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT_EN = 3'd2,
      S_XMIT    = 3'd3,
      S_GAP     = 3'd4
   } state_t;

   localparam logic [1:0] TYPE_VID = 2'b00;
   localparam logic [1:0] TYPE_AUD = 2'b01;
   localparam logic [1:0] TYPE_VAX = 2'b10;

   localparam logic [4:0] AUD_MAX_W   = {1'b0, AUD_MAX};
   localparam logic [4:0] VIDAX_MAX_W = {1'b0, VIDAX_MAX};
   // A zero-length gap still occupies one cycle.
   localparam logic [7:0] GAP_LEN     = (GAP_CYC == 8'd0) ? 8'd1 : GAP_CYC;

   state_t      state_q, state_d;
   logic        sched_go_q, sched_go_d;
   logic        busy_q, busy_d;
   logic [1:0]  pkt_type_q, pkt_type_d;
   logic [3:0]  ade_num_q, ade_num_d;
   logic        err_start_q, err_start_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] aud_age_q, aud_age_d;
   logic [7:0]  cyc_cnt_q, cyc_cnt_d;

   logic [4:0]  aud_min;
   logic [4:0]  vax_min;
   logic        aud_pending;
   logic        aud_due;

   always_comb begin
      // Mins are taken at full 5-bit width so levels of 16+ saturate, not wrap.
      aud_min     = (aud_level > AUD_MAX_W)   ? AUD_MAX_W   : aud_level;
      vax_min     = (aud_level > VIDAX_MAX_W) ? VIDAX_MAX_W : aud_level;
      aud_pending = (aud_level != 5'd0);
      aud_due     = aud_pending && ((aud_age_q >= AUD_WAIT) || !vid_ready);

      state_d     = state_q;
      pkt_type_d  = pkt_type_q;
      ade_num_d   = ade_num_q;
      err_start_d = err_start_q;
      pkt_cnt_d   = pkt_cnt_q;
      cyc_cnt_d   = cyc_cnt_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            cyc_cnt_d = 8'd0;
            if (aud_due) begin
               pkt_type_d = TYPE_AUD;
               ade_num_d  = aud_min[3:0];
               state_d    = S_ISSUE;
            end else if (vid_ready) begin
               pkt_type_d = aud_pending ? TYPE_VAX : TYPE_VID;
               ade_num_d  = aud_pending ? vax_min[3:0] : 4'd0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cyc_cnt_d = 8'd0;
            state_d   = S_WAIT_EN;
         end
         S_WAIT_EN: begin
            if (tx_en) begin
               cyc_cnt_d = 8'd0;
               state_d   = S_XMIT;
            end else if (cyc_cnt_q == START_TO - 8'd1) begin
               err_start_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_XMIT: begin
            cyc_cnt_d = 8'd0;
            if (!tx_en) begin
               pkt_cnt_d = pkt_cnt_q + 16'd1;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            if (cyc_cnt_q == GAP_LEN - 8'd1) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Granting aux blocks restarts the audio age, overriding the increment.
      if (!aud_pending) begin
         aud_age_d = 16'd0;
      end else if ((state_q == S_ISSUE) && (pkt_type_q != TYPE_VID)) begin
         aud_age_d = 16'd0;
      end else if (aud_age_q != 16'hFFFF) begin
         aud_age_d = aud_age_q + 16'd1;
      end else begin
         aud_age_d = aud_age_q;
      end

      sched_go_d = (state_d == S_ISSUE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge tx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         sched_go_q  <= 1'b0;
         busy_q      <= 1'b0;
         pkt_type_q  <= TYPE_VID;
         ade_num_q   <= 4'd0;
         err_start_q <= 1'b0;
         pkt_cnt_q   <= 16'd0;
         aud_age_q   <= 16'd0;
         cyc_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         sched_go_q  <= sched_go_d;
         busy_q      <= busy_d;
         pkt_type_q  <= pkt_type_d;
         ade_num_q   <= ade_num_d;
         err_start_q <= err_start_d;
         pkt_cnt_q   <= pkt_cnt_d;
         aud_age_q   <= aud_age_d;
         cyc_cnt_q   <= cyc_cnt_d;
      end
   end

   assign sched_go  = sched_go_q;
   assign busy      = busy_q;
   assign pkt_type  = pkt_type_q;
   assign ade_num   = ade_num_q;
   assign err_start = err_start_q;
   assign pkt_cnt   = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_gmii_tx_sched
// Brief   : Randomized self-checking bench for gmii_tx_sched.
// Revision: 1.0
// ============================================================================
module tb_gmii_tx_sched;

   localparam int T_AUD_MAX   = 8;
   localparam int T_VIDAX_MAX = 4;
   localparam int T_AUD_WAIT  = 10;
   localparam int T_START_TO  = 64;
   localparam int T_GAP       = 12;
   localparam int N_CYC       = 20000;

   localparam int P_IDLE = 0;
   localparam int P_GO   = 1;
   localparam int P_WAIT = 2;
   localparam int P_XMIT = 3;
   localparam int P_GAP  = 4;

   logic        tx_clk;
   logic        sys_rst;
   logic        vid_ready;
   logic [4:0]  aud_level;
   logic        tx_en;
   logic        sched_go;
   logic [1:0]  pkt_type;
   logic [3:0]  ade_num;
   logic        busy;
   logic        err_start;
   logic [15:0] pkt_cnt;

   gmii_tx_sched #(
      .AUD_MAX   (4'd8),
      .VIDAX_MAX (4'd4),
      .AUD_WAIT  (16'd10),
      .START_TO  (8'd64),
      .GAP_CYC   (8'd12)
   ) dut (
      .tx_clk    (tx_clk),
      .sys_rst   (sys_rst),
      .vid_ready (vid_ready),
      .aud_level (aud_level),
      .tx_en     (tx_en),
      .sched_go  (sched_go),
      .pkt_type  (pkt_type),
      .ade_num   (ade_num),
      .busy      (busy),
      .err_start (err_start),
      .pkt_cnt   (pkt_cnt)
   );

   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: a phase plus a countdown of cycles left in that phase.
   int m_ph, m_left, m_age, m_type, m_num, m_err, m_cnt;

   task automatic model_reset();
      m_ph = P_IDLE; m_left = 0; m_age = 0;
      m_type = 0; m_num = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input int v, input int l, input int t);
      int nxt_age;
      if (l == 0)                          nxt_age = 0;
      else if (m_ph == P_GO && m_type != 0) nxt_age = 0;
      else                                 nxt_age = (m_age >= 65535) ? 65535 : m_age + 1;
      case (m_ph)
         P_IDLE: begin
            if (l != 0 && (m_age >= T_AUD_WAIT || v == 0)) begin
               m_type = 1; m_num = (l > T_AUD_MAX) ? T_AUD_MAX : l; m_ph = P_GO;
            end else if (v != 0 && l != 0) begin
               m_type = 2; m_num = (l > T_VIDAX_MAX) ? T_VIDAX_MAX : l; m_ph = P_GO;
            end else if (v != 0) begin
               m_type = 0; m_num = 0; m_ph = P_GO;
            end
         end
         P_GO: begin
            m_ph = P_WAIT; m_left = T_START_TO;
         end
         P_WAIT: begin
            if (t != 0) m_ph = P_XMIT;
            else begin
               m_left--;
               if (m_left == 0) begin m_err = 1; m_ph = P_IDLE; end
            end
         end
         P_XMIT: begin
            if (t == 0) begin
               m_cnt = (m_cnt + 1) % 65536;
               m_ph = P_GAP; m_left = (T_GAP == 0) ? 1 : T_GAP;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) m_ph = P_IDLE;
         end
      endcase
      m_age = nxt_age;
   endtask

   task automatic compare_all();
      chk("sched_go",  int'(sched_go),  (m_ph == P_GO) ? 1 : 0);
      chk("busy",      int'(busy),      (m_ph != P_IDLE) ? 1 : 0);
      chk("pkt_type",  int'(pkt_type),  m_type);
      chk("ade_num",   int'(ade_num),   m_num);
      chk("err_start", int'(err_start), m_err);
      chk("pkt_cnt",   int'(pkt_cnt),   m_cnt);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_sched_go"},  int'(sched_go),  0);
      chk({tag, "_busy"},      int'(busy),      0);
      chk({tag, "_pkt_type"},  int'(pkt_type),  0);
      chk({tag, "_ade_num"},   int'(ade_num),   0);
      chk({tag, "_err_start"}, int'(err_start), 0);
      chk({tag, "_pkt_cnt"},   int'(pkt_cnt),   0);
   endtask

   task automatic drive_levels();
      int r;
      if ($urandom_range(0, 5) == 0) vid_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) begin
         r = $urandom_range(0, 3);
         case (r)
            0:       aud_level = 5'd0;
            1:       aud_level = 5'($urandom_range(1, 4));
            2:       aud_level = 5'($urandom_range(5, 15));
            default: aud_level = 5'($urandom_range(16, 31));
         endcase
      end
   endtask

   int  tx_delay, tx_len, n_rst;
   bit  want_preload, forcing;

   initial begin
      sys_rst = 1'b0; vid_ready = 1'b0; aud_level = 5'd0; tx_en = 1'b0;
      tx_delay = 0; tx_len = 0; n_rst = 0; want_preload = 1'b0; forcing = 1'b0;
      #2 sys_rst = 1'b1;
      #1 check_reset_values("por");
      model_reset();
      @(posedge tx_clk);
      @(posedge tx_clk);
      #1 sys_rst = 1'b0;

      for (int c = 0; c < N_CYC; c++) begin
         @(posedge tx_clk);
         if (sys_rst) model_reset();
         else         model_edge(int'(vid_ready), int'(aud_level), int'(tx_en));
         #1;
         sys_rst = 1'b0;
         if (forcing) begin
            release dut.pkt_cnt_q;
            forcing = 1'b0;
            m_cnt = 65535;
         end
         compare_all();

         // Abort a packet mid-transmission; outputs must clear without a clock edge.
         if (m_ph == P_XMIT && n_rst < 4 && $urandom_range(0, 149) == 0) begin
            n_rst++;
            #2 sys_rst = 1'b1;
            #1 check_reset_values("midrst");
            model_reset();
            tx_delay = 0; tx_len = 0;
         end

         if (c == N_CYC / 2) want_preload = 1'b1;
         if (want_preload && !sys_rst && m_ph != P_XMIT) begin
            force dut.pkt_cnt_q = 16'hFFFF;
            forcing = 1'b1;
            want_preload = 1'b0;
         end

         drive_levels();
         case (m_ph)
            P_GO: begin
               tx_delay = ($urandom_range(0, 7) == 0) ? 80 : $urandom_range(0, 5);
               tx_len   = $urandom_range(1, 40);
               tx_en    = 1'b0;
            end
            P_WAIT: begin
               if (tx_delay == 0) tx_en = 1'b1;
               else begin tx_delay--; tx_en = 1'b0; end
            end
            P_XMIT: begin
               if (tx_len > 0) begin tx_en = 1'b1; tx_len--; end
               else tx_en = 1'b0;
            end
            default: tx_en = ($urandom_range(0, 11) == 0);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gmii_tx_sched.md
GMII_TX_SCHED -- requirements
Module: gmii_tx_sched

Interface
REQ-001 Parameter AUD_MAX, default 4'd8: maximum aux blocks in an audio-only packet.
REQ-002 Parameter VIDAX_MAX, default 4'd4: maximum aux blocks appended to a video packet.
REQ-003 Parameter AUD_WAIT, default 16'd2000: audio age, in cycles, at which audio takes priority over video.
REQ-004 Parameter START_TO, default 8'd64: cycles to wait for tx_en to rise after a grant.
REQ-005 Parameter GAP_CYC, default 8'd12: idle cycles enforced after tx_en falls.
REQ-006 tx_clk  in  1  sole clock; all logic is on its rising edge.
REQ-007 sys_rst  in  1  asynchronous, active-high reset.
REQ-008 vid_ready  in  1  level; one video line is buffered and ready to send.
REQ-009 aud_level  in  5  count of 34-byte aux blocks available in the aux FIFO.
REQ-010 tx_en  in  1  GMII transmit enable driven by the transmitter.
REQ-011 sched_go  out  1  one-cycle start pulse to the transmitter.
REQ-012 pkt_type  out  2  packet type: 2'b00 video, 2'b01 audio, 2'b10 video+aux; held until the next grant.
REQ-013 ade_num  out  4  aux block count for the granted packet; held until the next grant.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err_start  out  1  sticky flag, set on a start timeout.
REQ-016 pkt_cnt  out  16  count of packets completed; wraps at 16'hFFFF to 0.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_EN, XMIT and GAP.
REQ-018 IDLE: the decision is evaluated every cycle; if any packet is selected, the FSM SHALL latch pkt_type/ade_num and go to ISSUE on the next edge.
REQ-019 Decision rule 1: if aud_level != 0 and (aud_age >= AUD_WAIT or vid_ready == 0), the grant SHALL be audio, with ade_num = min(aud_level, AUD_MAX).
REQ-020 Decision rule 2: otherwise, if vid_ready == 1 and aud_level != 0, the grant SHALL be video+aux, with ade_num = min(aud_level, VIDAX_MAX).
REQ-021 Decision rule 3: otherwise, if vid_ready == 1, the grant SHALL be video, with ade_num = 0.
REQ-022 Decision rule 4: otherwise the FSM SHALL stay in IDLE.
REQ-023 The min comparisons SHALL be done at 5 bits, with the parameter zero-extended; the result SHALL be truncated to 4 bits only after the min (an aud_level of 16 or more never wraps).
REQ-024 ISSUE: sched_go = 1 for exactly this one cycle, then WAIT_EN; latency from qualifying inputs in IDLE to sched_go is 1 cycle.
REQ-025 WAIT_EN: a cycle counter runs from 0.
  - tx_en == 1 -> XMIT.
  - Counter reaches START_TO-1 with tx_en still 0 -> set err_start, go to IDLE; pkt_cnt is not incremented.
REQ-026 XMIT: on tx_en == 0, pkt_cnt increments and the FSM goes to GAP; there is no upper time bound on XMIT.
REQ-027 GAP: the FSM stays exactly GAP_CYC cycles, then goes to IDLE; if GAP_CYC == 0, GAP lasts 1 cycle.
REQ-028 aud_age is a 16-bit counter, saturating at 16'hFFFF.
  - Increments each cycle that aud_level != 0.
  - Clears to 0 when aud_level == 0.
  - Clears to 0 in the ISSUE cycle of an audio or video+aux grant; this clear takes precedence over the increment.
REQ-029 Inputs sampled in any state other than IDLE SHALL NOT change pkt_type or ade_num.
REQ-030 A tx_en pulse while in IDLE or GAP SHALL be ignored: no state change, no pkt_cnt change.
REQ-031 Simultaneous vid_ready and aud_level != 0 with aud_age < AUD_WAIT SHALL always yield video+aux, never audio.

Reset
REQ-032 While sys_rst = 1, asynchronously:
  - state = IDLE
  - sched_go = 0, busy = 0
  - pkt_type = 2'b00, ade_num = 0
  - err_start = 0, pkt_cnt = 0
  - aud_age = 0 and all internal counters = 0
REQ-033 Reset asserted mid-packet SHALL abort to IDLE immediately; no sched_go is issued within 1 cycle after deassertion unless the inputs qualify.
REQ-034 err_start SHALL be cleared only by sys_rst.

Verification
REQ-035 vid_ready = 1, aud_level = 0 -> sched_go 1 cycle later, pkt_type = 00, ade_num = 0; tx_en high 100 cycles then low -> pkt_cnt = 1; next sched_go no earlier than GAP_CYC+1 cycles after tx_en falls.
REQ-036 vid_ready = 1, aud_level = 9 -> pkt_type = 10, ade_num = 4; then vid_ready = 0, aud_level = 20 -> pkt_type = 01, ade_num = 8.
REQ-037 vid_ready held 1, aud_level = 3, tx_en never rises -> err_start = 1 after 64 cycles in WAIT_EN, FSM back in IDLE, pkt_cnt unchanged.
REQ-038 AUD_WAIT = 10; audio pending while a long video packet is in XMIT -> the next grant after GAP is audio (01), even with vid_ready = 1.
REQ-039 Assert sys_rst during XMIT -> all outputs at reset values in the same cycle; pkt_cnt preload 16'hFFFF plus one completed packet -> 0.
REQ-040 A tx_en pulse while in IDLE or GAP -> no state change and pkt_cnt unchanged.
